// File: rtl/machine_counter_unit_pkg.sv
// machine_counter_unit_pkg: CSR addresses and mcountinhibit bit indices for the machine counters
package machine_counter_unit_pkg;
  localparam logic [11:0] MCYCLE    = 12'hB00;
  localparam logic [11:0] MINSTRET  = 12'hB02;
  localparam logic [11:0] MCYCLEH   = 12'hB80;
  localparam logic [11:0] MINSTRETH = 12'hB82;
  localparam logic [11:0] CYCLE     = 12'hC00;
  localparam logic [11:0] INSTRET   = 12'hC02;
  localparam logic [11:0] CYCLEH    = 12'hC80;
  localparam logic [11:0] INSTRETH  = 12'hC82;
  localparam int INHIBIT_CY = 0;
  localparam int INHIBIT_IR = 2;
endpackage

// File: rtl/counter64_rv32.sv
// counter64_rv32: 64-bit counter with 32-bit half writes, increment and registered wrap pulse
module counter64_rv32 (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        inc_in,
  input  logic        wr_lo_in,
  input  logic        wr_hi_in,
  input  logic [31:0] data_in,
  output logic [63:0] cnt_out,
  output logic        wrap_out
);
  logic wr;
  assign wr = wr_lo_in | wr_hi_in;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      cnt_out  <= '0;
      wrap_out <= 1'b0;
    end else begin
      cnt_out  <= wr ? {wr_hi_in ? data_in : cnt_out[63:32], wr_lo_in ? data_in : cnt_out[31:0]}
                     : inc_in ? cnt_out + 64'd1 : cnt_out;
      wrap_out <= !wr && inc_in && &cnt_out;
    end
endmodule

// File: rtl/machine_counter_unit.sv
// machine_counter_unit: mcycle/minstret counters with CSR decode, write fan-out and read mux
module machine_counter_unit
  import machine_counter_unit_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mcountinhibit_cy_in,
  input  logic        mcountinhibit_ir_in,
  input  logic        instret_inc_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] data_wr_in,
  output logic [63:0] mcycle_out,
  output logic [63:0] minstret_out,
  output logic [31:0] csr_data_out,
  output logic        csr_hit_out,
  output logic        mcycle_wrap_out,
  output logic        minstret_wrap_out
);
  logic cy_lo, cy_hi, ir_lo, ir_hi;
  assign cy_lo = csr_addr_in == MCYCLE    || csr_addr_in == CYCLE;
  assign cy_hi = csr_addr_in == MCYCLEH   || csr_addr_in == CYCLEH;
  assign ir_lo = csr_addr_in == MINSTRET  || csr_addr_in == INSTRET;
  assign ir_hi = csr_addr_in == MINSTRETH || csr_addr_in == INSTRETH;
  assign csr_hit_out = cy_lo | cy_hi | ir_lo | ir_hi;
  always_comb
    csr_data_out = cy_lo ? mcycle_out[31:0] : cy_hi ? mcycle_out[63:32]
                 : ir_lo ? minstret_out[31:0] : ir_hi ? minstret_out[63:32] : 32'd0;
  // user aliases decode for reads only; writes go to the M-mode addresses alone
  counter64_rv32 u_mcycle (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .inc_in   (!mcountinhibit_cy_in),
    .wr_lo_in (wr_en_in && csr_addr_in == MCYCLE),
    .wr_hi_in (wr_en_in && csr_addr_in == MCYCLEH),
    .data_in  (data_wr_in),
    .cnt_out  (mcycle_out),
    .wrap_out (mcycle_wrap_out)
  );
  counter64_rv32 u_minstret (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .inc_in   (instret_inc_in && !mcountinhibit_ir_in),
    .wr_lo_in (wr_en_in && csr_addr_in == MINSTRET),
    .wr_hi_in (wr_en_in && csr_addr_in == MINSTRETH),
    .data_in  (data_wr_in),
    .cnt_out  (minstret_out),
    .wrap_out (minstret_wrap_out)
  );
endmodule

// File: tb/tb_machine_counter_unit.sv
// tb_machine_counter_unit: directed and random checks of the machine counters against a reference model
module tb_machine_counter_unit;
  logic        clk_in = 0, rst_in = 1;
  logic        inh_cy = 1, inh_ir = 0, inc = 0, wr_en = 0;
  logic [11:0] addr = 12'hB00;
  logic [31:0] data = 0;
  logic [63:0] mcycle_out, minstret_out;
  logic [31:0] csr_data_out;
  logic        csr_hit_out, mcycle_wrap_out, minstret_wrap_out;
  logic [63:0] m_cy, m_ir;
  logic        m_cw, m_iw;
  int total = 0, bad = 0;

  machine_counter_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .mcountinhibit_cy_in(inh_cy), .mcountinhibit_ir_in(inh_ir),
    .instret_inc_in(inc), .wr_en_in(wr_en), .csr_addr_in(addr), .data_wr_in(data),
    .mcycle_out(mcycle_out), .minstret_out(minstret_out), .csr_data_out(csr_data_out),
    .csr_hit_out(csr_hit_out), .mcycle_wrap_out(mcycle_wrap_out), .minstret_wrap_out(minstret_wrap_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    case (a)
      12'hB00, 12'hC00: return m_cy[31:0];
      12'hB80, 12'hC80: return m_cy[63:32];
      12'hB02, 12'hC02: return m_ir[31:0];
      12'hB82, 12'hC82: return m_ir[63:32];
      default:          return 32'd0;
    endcase
  endfunction

  function automatic logic exp_hit(input logic [11:0] a);
    return a inside {12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82};
  endfunction

  task automatic model_reset();
    m_cy = 0; m_ir = 0; m_cw = 0; m_iw = 0;
  endtask

  // advance one clock; the model applies the rules to the inputs held across the edge
  task automatic cyc();
    logic [64:0] s;
    logic [63:0] n_cy = m_cy, n_ir = m_ir;
    logic n_cw = 0, n_iw = 0;
    if (wr_en && addr == 12'hB00) n_cy[31:0] = data;
    else if (wr_en && addr == 12'hB80) n_cy[63:32] = data;
    else if (!inh_cy) begin s = {1'b0, m_cy} + 65'd1; n_cy = s[63:0]; n_cw = s[64]; end
    if (wr_en && addr == 12'hB02) n_ir[31:0] = data;
    else if (wr_en && addr == 12'hB82) n_ir[63:32] = data;
    else if (inc && !inh_ir) begin s = {1'b0, m_ir} + 65'd1; n_ir = s[63:0]; n_iw = s[64]; end
    @(posedge clk_in); #1;
    m_cy = n_cy; m_ir = n_ir; m_cw = n_cw; m_iw = n_iw;
  endtask

  task automatic write(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1; addr = a; data = d; cyc(); wr_en = 0;
  endtask

  task automatic test_reset();
    #12; rst_in = 0; model_reset();
    #1;
    total++; if (mcycle_out !== 64'd0) begin bad++; $display("FAIL reset_mcycle got %h want 0", mcycle_out); end
    total++; if (minstret_out !== 64'd0) begin bad++; $display("FAIL reset_minstret got %h want 0", minstret_out); end
    total++; if ({mcycle_wrap_out, minstret_wrap_out} !== 2'b00) begin bad++; $display("FAIL reset_wrap got %b want 00", {mcycle_wrap_out, minstret_wrap_out}); end
    total++; if (csr_hit_out !== 1'b1 || csr_data_out !== 32'd0) begin bad++; $display("FAIL reset_read hit=%b data=%h want 1/0", csr_hit_out, csr_data_out); end
  endtask

  task automatic test_count();
    @(negedge clk_in); inh_cy = 0;
    repeat (10) cyc();
    total++; if (mcycle_out !== 64'd10) begin bad++; $display("FAIL count_mcycle got %0d want 10", mcycle_out); end
    total++; if (minstret_out !== 64'd0) begin bad++; $display("FAIL count_minstret got %0d want 0", minstret_out); end
  endtask

  task automatic test_carry();
    write(12'hB00, 32'hFFFF_FFFF);
    total++; if (mcycle_out !== 64'h0000_0000_FFFF_FFFF) begin bad++; $display("FAIL carry_write got %h want 00000000ffffffff", mcycle_out); end
    repeat (2) cyc();
    total++; if (mcycle_out !== 64'h0000_0001_0000_0001) begin bad++; $display("FAIL carry_count got %h want 0000000100000001", mcycle_out); end
  endtask

  task automatic test_wrap();
    write(12'hB80, 32'hFFFF_FFFF);
    write(12'hB00, 32'hFFFF_FFFF);
    total++; if (mcycle_out !== 64'hFFFF_FFFF_FFFF_FFFF || mcycle_wrap_out !== 1'b0) begin bad++; $display("FAIL wrap_setup got %h/%b want all ones/0", mcycle_out, mcycle_wrap_out); end
    cyc();
    total++; if (mcycle_out !== 64'd0 || mcycle_wrap_out !== 1'b1) begin bad++; $display("FAIL wrap_pulse got %h/%b want 0/1", mcycle_out, mcycle_wrap_out); end
    cyc();
    total++; if (mcycle_out !== 64'd1 || mcycle_wrap_out !== 1'b0) begin bad++; $display("FAIL wrap_end got %h/%b want 1/0", mcycle_out, mcycle_wrap_out); end
    write(12'hB00, 32'd0); write(12'hB80, 32'd0);
    total++; if (mcycle_wrap_out !== 1'b0) begin bad++; $display("FAIL wrap_on_write got %b want 0", mcycle_wrap_out); end
  endtask

  task automatic test_write_priority();
    logic [63:0] cy0 = m_cy;
    inc = 1; write(12'hB02, 32'h5); inc = 0;
    total++; if (minstret_out !== 64'd5) begin bad++; $display("FAIL prio_minstret got %0d want 5", minstret_out); end
    total++; if (mcycle_out !== cy0 + 64'd1) begin bad++; $display("FAIL prio_mcycle got %h want %h", mcycle_out, cy0 + 64'd1); end
    addr = 12'hB00; wr_en = 1; data = 32'h1234_5678; #1;
    total++; if (csr_data_out !== m_cy[31:0]) begin bad++; $display("FAIL rdw_before got %h want %h", csr_data_out, m_cy[31:0]); end
    cyc(); wr_en = 0; #1;
    total++; if (csr_data_out !== 32'h1234_5678) begin bad++; $display("FAIL rdw_after got %h want 12345678", csr_data_out); end
  endtask

  task automatic test_inhibit_ir();
    logic [63:0] ir0 = m_ir;
    inh_ir = 1; inc = 1;
    repeat (5) cyc();
    total++; if (minstret_out !== ir0) begin bad++; $display("FAIL ir_inhibit got %h want %h", minstret_out, ir0); end
    addr = 12'hC02; data = 32'hDEAD_BEEF; #1;
    total++; if (csr_hit_out !== 1'b1) begin bad++; $display("FAIL alias_hit got %b want 1", csr_hit_out); end
    write(12'hC02, 32'hDEAD_BEEF);
    total++; if (minstret_out !== ir0) begin bad++; $display("FAIL alias_write got %h want %h", minstret_out, ir0); end
    write(12'hB82, 32'hA5A5_0001);
    addr = 12'hC82; #1;
    total++; if (csr_data_out !== 32'hA5A5_0001) begin bad++; $display("FAIL alias_c82 got %h want a5a50001", csr_data_out); end
    addr = 12'hB82; #1;
    total++; if (csr_data_out !== 32'hA5A5_0001) begin bad++; $display("FAIL read_b82 got %h want a5a50001", csr_data_out); end
    inh_ir = 0; inc = 0;
  endtask

  task automatic test_minstret_wrap();
    write(12'hB82, 32'hFFFF_FFFF); write(12'hB02, 32'hFFFF_FFFE);
    inc = 1; cyc();
    total++; if (minstret_out !== 64'hFFFF_FFFF_FFFF_FFFF || minstret_wrap_out !== 1'b0) begin bad++; $display("FAIL irwrap_pre got %h/%b", minstret_out, minstret_wrap_out); end
    cyc();
    total++; if (minstret_out !== 64'd0 || minstret_wrap_out !== 1'b1) begin bad++; $display("FAIL irwrap_pulse got %h/%b want 0/1", minstret_out, minstret_wrap_out); end
    inc = 0; cyc();
    total++; if (minstret_out !== 64'd0 || minstret_wrap_out !== 1'b0) begin bad++; $display("FAIL irwrap_end got %h/%b want 0/0", minstret_out, minstret_wrap_out); end
  endtask

  task automatic test_async_reset();
    inh_cy = 0; inh_ir = 0; inc = 1;
    repeat (3) cyc();
    #2 rst_in = 1; #1;
    total++; if (mcycle_out !== 64'd0 || minstret_out !== 64'd0) begin bad++; $display("FAIL async_rst got %h/%h want 0/0", mcycle_out, minstret_out); end
    #1 rst_in = 0; model_reset();
    cyc();
    total++; if (mcycle_out !== 64'd1 || minstret_out !== 64'd1) begin bad++; $display("FAIL async_resume got %h/%h want 1/1", mcycle_out, minstret_out); end
  endtask

  task automatic test_random();
    logic [11:0] tbl [8] = '{12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82};
    for (int i = 0; i < 300; i++) begin
      int k = $urandom_range(0, 8);
      inh_cy = $urandom_range(0, 3) == 0;
      inh_ir = $urandom_range(0, 3) == 0;
      inc    = $urandom_range(0, 1) == 1;
      wr_en  = $urandom_range(0, 2) == 0;
      addr   = k == 8 ? 12'($urandom_range(0, 255)) : tbl[k];
      data   = $urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : $urandom;
      #1;
      total++; if (csr_data_out !== exp_read(addr) || csr_hit_out !== exp_hit(addr)) begin bad++; $display("FAIL rnd_read i=%0d addr=%h got %h/%b want %h/%b", i, addr, csr_data_out, csr_hit_out, exp_read(addr), exp_hit(addr)); end
      cyc();
      total++; if (mcycle_out !== m_cy || minstret_out !== m_ir || mcycle_wrap_out !== m_cw || minstret_wrap_out !== m_iw) begin bad++; $display("FAIL rnd_state i=%0d got %h %h %b%b want %h %h %b%b", i, mcycle_out, minstret_out, mcycle_wrap_out, minstret_wrap_out, m_cy, m_ir, m_cw, m_iw); end
    end
    wr_en = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_carry();
    test_wrap();
    test_write_priority();
    test_inhibit_ir();
    test_minstret_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
